// File: rtl/ap3_alu_seq.sv
// ap3_alu_seq: slice-serial adder/subtractor with valid/ready handshakes; AP3_ALU_SEQ_FLAGS_EN adds ovf/zero flags
module ap3_alu_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] x,
    output logic             co
`ifdef AP3_ALU_SEQ_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);
    localparam int N = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [WIDTH-1:0] MASK = WIDTH'({SLICE{1'b1}});

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] aa_q, aa_d, bb_q, bb_d, y_q, y_d;
    logic             carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [31:0]      base;
    logic [SLICE-1:0] a_s, b_s;
    logic [SLICE:0]   sum_s;
    logic [WIDTH-1:0] slice_mask;

    // Select the active slice of both operands and add it with the running carry
    always_comb begin
        base = 32'(idx_q) * 32'(SLICE);
        a_s = SLICE'(aa_q >> base);
        b_s = SLICE'(bb_q >> base);
        sum_s = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, carry_q};
        slice_mask = MASK << base;
    end

    // Next-state logic: latch operands on accept, one slice per RUN cycle, hold results in DONE
    always_comb begin
        state_d = state_q;
        aa_d = aa_q;
        bb_d = bb_q;
        y_d = y_q;
        carry_d = carry_q;
        idx_d = idx_q;
        unique case (state_q)
            IDLE: if (in_valid) begin
                aa_d = a;
                bb_d = bi ? ~b : b;
                carry_d = ci;
                idx_d = '0;
                y_d = '0;
                state_d = RUN;
            end
            RUN: begin
                y_d = (y_q & ~slice_mask) | (WIDTH'(sum_s[SLICE-1:0]) << base);
                carry_d = sum_s[SLICE];
                idx_d = idx_q + IW'(1);
                state_d = (idx_q == LAST) ? DONE : RUN;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset wins over any handshake in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            aa_q <= '0;
            bb_q <= '0;
            y_q <= '0;
            carry_q <= 1'b0;
            idx_q <= '0;
        end else begin
            state_q <= state_d;
            aa_q <= aa_d;
            bb_q <= bb_d;
            y_q <= y_d;
            carry_q <= carry_d;
            idx_q <= idx_d;
        end
    end

    assign in_ready = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign y = y_q;
    assign x = aa_q ^ bb_q;
    assign co = out_valid & carry_q;
`ifdef AP3_ALU_SEQ_FLAGS_EN
    // Carry into the top bit is recovered as x ^ y at that bit
    assign ovf = out_valid & (x[WIDTH-1] ^ y_q[WIDTH-1] ^ carry_q);
    assign zero = out_valid & (y_q == '0);
`endif
endmodule

// File: tb/tb_ap3_alu_seq.sv
// tb_ap3_alu_seq: randomized and directed self-checking bench for ap3_alu_seq
module tb_ap3_alu_seq;
    localparam int WIDTH = 32;
    localparam int SLICE = 8;
    localparam int N = WIDTH / SLICE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic bi = 1'b0;
    logic ci = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic in_ready, out_valid, co;
    logic [31:0] y, x;
`ifdef AP3_ALU_SEQ_FLAGS_EN
    logic ovf, zero;
`endif
    int tests = 0;
    int fails = 0;

    logic [31:0] va [3] = '{32'h000000FF, 32'h5, 32'hFFFFFFFF};
    logic [31:0] vb [3] = '{32'h1, 32'h7, 32'h1};
    logic        vbi [3] = '{1'b0, 1'b1, 1'b0};
    logic        vci [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] vy [3] = '{32'h00000100, 32'hFFFFFFFE, 32'h00000000};
    logic [31:0] vx [3] = '{32'h000000FE, 32'hFFFFFFFD, 32'hFFFFFFFE};
    logic        vco [3] = '{1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    ap3_alu_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bi(bi), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .x(x), .co(co)
`ifdef AP3_ALU_SEQ_FLAGS_EN
        , .ovf(ovf), .zero(zero)
`endif
    );

    function automatic logic [32:0] ref_sum(input logic [31:0] ra, input logic [31:0] rb, input logic rbi, input logic rci);
        logic [31:0] ob = rbi ? ~rb : rb;
        return {1'b0, ra} + {1'b0, ob} + 33'(rci);
    endfunction

    function automatic logic [31:0] ref_x(input logic [31:0] ra, input logic [31:0] rb, input logic rbi);
        return ra ^ (rbi ? ~rb : rb);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [31:0] ra, input logic [31:0] rb, input logic rbi, input logic rci);
        int w = 0;
        while (!in_ready && w < 50) begin
            step();
            w++;
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL start_in_ready got %b exp 1", in_ready);
        end
        a = ra;
        b = rb;
        bi = rbi;
        ci = rci;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            a = $urandom;
            b = $urandom;
            bi = 1'($urandom);
            ci = 1'($urandom);
            in_valid = 1'($urandom);
            step();
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        a = 32'h12345678;
        step();
        step();
        tests++;
        if ({in_ready, out_valid, co} !== 3'b100) begin
            fails++;
            $display("FAIL reset_ctrl got %b exp 100", {in_ready, out_valid, co});
        end
        tests++;
        if ({y, x} !== 64'h0) begin
            fails++;
            $display("FAIL reset_yx got %h/%h exp 0/0", y, x);
        end
`ifdef AP3_ALU_SEQ_FLAGS_EN
        tests++;
        if ({ovf, zero} !== 2'b00) begin
            fails++;
            $display("FAIL reset_flags got %b exp 00", {ovf, zero});
        end
`endif
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            fails++;
            $display("FAIL post_reset_idle got %b exp 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_directed();
        int lat;
        for (int i = 0; i < 3; i++) begin
            start_op(va[i], vb[i], vbi[i], vci[i]);
            wait_done(lat);
            tests++;
            if (lat != N) begin
                fails++;
                $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, N);
            end
            tests++;
            if ({co, y, x} !== {vco[i], vy[i], vx[i]}) begin
                fails++;
                $display("FAIL dir%0d_result got co=%b y=%h x=%h exp co=%b y=%h x=%h", i, co, y, x, vco[i], vy[i], vx[i]);
            end
            finish_op();
        end
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] ra, rb;
        logic rbi, rci;
        logic [32:0] s;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = (i % 5 == 0) ? ~ra : $urandom;
            rbi = 1'($urandom);
            rci = 1'($urandom);
            s = ref_sum(ra, rb, rbi, rci);
            start_op(ra, rb, rbi, rci);
            wait_done(lat);
            tests++;
            if (lat != N || {co, y, x} !== {s, ref_x(ra, rb, rbi)}) begin
                fails++;
                $display("FAIL rand%0d got lat=%0d co=%b y=%h x=%h exp lat=%0d co=%b y=%h x=%h", i, lat, co, y, x, N, s[32], s[31:0], ref_x(ra, rb, rbi));
            end
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] ra = $urandom, rb = $urandom, na = $urandom, nb = $urandom;
        logic [32:0] s = ref_sum(ra, rb, 1'b1, 1'b0);
        logic [32:0] ns = ref_sum(na, nb, 1'b0, 1'b1);
        start_op(ra, rb, 1'b1, 1'b0);
        wait_done(lat);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom;
            bi = 1'($urandom);
            ci = 1'($urandom);
            step();
            tests++;
            if ({in_ready, out_valid, co, y, x} !== {2'b01, s, ref_x(ra, rb, 1'b1)}) begin
                fails++;
                $display("FAIL hold%0d got rdy=%b vld=%b co=%b y=%h x=%h exp rdy=0 vld=1 co=%b y=%h x=%h", i, in_ready, out_valid, co, y, x, s[32], s[31:0], ref_x(ra, rb, 1'b1));
            end
        end
        a = na;
        b = nb;
        bi = 1'b0;
        ci = 1'b1;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            fails++;
            $display("FAIL out_hs_no_accept got %b exp 10", {in_ready, out_valid});
        end
        step();
        in_valid = 1'b0;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL accept_after_hs got in_ready=%b exp 0", in_ready);
        end
        wait_done(lat);
        tests++;
        if (lat != N || {co, y} !== ns) begin
            fails++;
            $display("FAIL bp_next_op got lat=%0d co=%b y=%h exp lat=%0d co=%b y=%h", lat, co, y, N, ns[32], ns[31:0]);
        end
        finish_op();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        start_op($urandom, $urandom, 1'b0, 1'b1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if ({in_ready, out_valid, co, y, x} !== {3'b100, 64'h0}) begin
            fails++;
            $display("FAIL rst_mid_run got rdy=%b vld=%b co=%b y=%h x=%h exp 1 0 0 0 0", in_ready, out_valid, co, y, x);
        end
        start_op(32'd3, 32'd4, 1'b0, 1'b0);
        wait_done(lat);
        tests++;
        if (lat != N || {co, y} !== 33'd7) begin
            fails++;
            $display("FAIL op_after_rst got lat=%0d co=%b y=%h exp lat=%0d co=0 y=7", lat, co, y, N);
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tests++;
        if ({in_ready, out_valid, y} !== {2'b10, 32'h0}) begin
            fails++;
            $display("FAIL rst_priority got rdy=%b vld=%b y=%h exp 1 0 0", in_ready, out_valid, y);
        end
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        int lat = 0;
        logic [31:0] y1 = '0;
        logic [31:0] p1a = $urandom, p1b = $urandom, p2a = $urandom, p2b = $urandom;
        logic [32:0] s1 = ref_sum(p1a, p1b, 1'b0, 1'b0);
        logic [32:0] s2 = ref_sum(p2a, p2b, 1'b1, 1'b1);
        out_ready = 1'b1;
        a = p1a;
        b = p1b;
        bi = 1'b0;
        ci = 1'b0;
        in_valid = 1'b1;
        step();
        a = p2a;
        b = p2b;
        bi = 1'b1;
        ci = 1'b1;
        while (!in_ready && cnt < 20) begin
            if (out_valid) y1 = y;
            step();
            cnt++;
        end
        step();
        cnt++;
        in_valid = 1'b0;
        tests++;
        if (cnt != N + 2 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL b2b_spacing got %0d cycles rdy=%b exp %0d cycles rdy=0", cnt, in_ready, N + 2);
        end
        tests++;
        if (y1 !== s1[31:0]) begin
            fails++;
            $display("FAIL b2b_first got %h exp %h", y1, s1[31:0]);
        end
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        tests++;
        if (lat != N || {co, y} !== s2) begin
            fails++;
            $display("FAIL b2b_second got lat=%0d co=%b y=%h exp lat=%0d co=%b y=%h", lat, co, y, N, s2[32], s2[31:0]);
        end
        step();
        out_ready = 1'b0;
    endtask

`ifdef AP3_ALU_SEQ_FLAGS_EN
    task automatic test_flags();
        int lat;
        logic [31:0] ra, rb, ob;
        logic rbi, rci, eovf;
        logic [32:0] s;
        longint sv;
        for (int i = 0; i < 22; i++) begin
            ra = (i == 0) ? 32'h7FFFFFFF : (i == 1) ? 32'h1 : $urandom;
            rb = (i < 2) ? 32'h1 : $urandom;
            rbi = (i == 1) ? 1'b1 : (i == 0) ? 1'b0 : 1'($urandom);
            rci = (i == 1) ? 1'b1 : (i == 0) ? 1'b0 : 1'($urandom);
            ob = rbi ? ~rb : rb;
            s = ref_sum(ra, rb, rbi, rci);
            sv = longint'($signed(ra)) + longint'($signed(ob)) + longint'(rci);
            eovf = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
            start_op(ra, rb, rbi, rci);
            wait_done(lat);
            tests++;
            if ({ovf, zero, co} !== {eovf, s[31:0] == 32'h0, s[32]}) begin
                fails++;
                $display("FAIL flags%0d got ovf=%b zero=%b co=%b exp ovf=%b zero=%b co=%b", i, ovf, zero, co, eovf, s[31:0] == 32'h0, s[32]);
            end
            finish_op();
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
`ifdef AP3_ALU_SEQ_FLAGS_EN
        test_flags();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ap3_alu_seq.md
AP3_ALU_SEQ -- requirements
Module: ap3_alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter SLICE, default 8, bits added per cycle; WIDTH % SLICE == 0, SLICE >= 1.
REQ-003 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready at clk edge.
REQ-007 SHALL have ports a, b  input  WIDTH  operands; bi  input  1  invert b; ci  input  1  carry-in.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready at clk edge.
REQ-010 SHALL have ports y  output  WIDTH  sum; x  output  WIDTH  propagate vector a ^ bb; co  output  1  final carry.

Function
REQ-011 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; in_ready = (state == IDLE), out_valid = (state == DONE).
REQ-012 SHALL on accept latch aa = a, bb = bi ? ~b : b, carry = ci, slice index = 0, clear y, and enter RUN.
REQ-013 SHALL in each RUN cycle add aa/bb slice[idx] (bits idx*SLICE+SLICE-1..idx*SLICE) plus carry, write the sum to y slice[idx], register the slice carry-out into carry, and increment idx.
REQ-014 SHALL enter DONE on the edge completing slice N-1, N = WIDTH/SLICE; out_valid is high exactly N cycles after the accept edge (SLICE == WIDTH gives 1).
REQ-015 SHALL drive x = aa ^ bb from the accept edge onward and co = carry out of bit WIDTH-1 in DONE.
REQ-016 SHALL hold y, x, co stable in DONE until the out handshake, then return to IDLE; the next accept occurs no earlier than the following cycle (throughput one op per N+2 cycles).
REQ-017 SHALL ignore in_valid, a, b, bi, ci while not in IDLE; operands changing during RUN do not affect the result.
REQ-018 SHALL compute modulo 2^WIDTH; the carry out of the top slice appears only on co.

Reset
REQ-019 SHALL on rst (any state, including mid-RUN) at the next clk edge enter IDLE and set y = 0, x = 0, co = 0, carry = 0, idx = 0, out_valid = 0, in_ready = 1.
REQ-020 SHALL give rst priority over a simultaneous in or out handshake; a handshake in that cycle is discarded.

Configuration
REQ-021 SHALL, with macro AP3_ALU_SEQ_FLAGS_EN defined, add outputs ovf (1 bit, carry into bit WIDTH-1 xor co) and zero (1 bit, y == 0), valid in DONE and reset to 0.
REQ-022 SHALL, without AP3_ALU_SEQ_FLAGS_EN, omit ports ovf and zero and their logic; all other behaviour is identical.

Verification (WIDTH=32, SLICE=8)
REQ-023 SHALL cover: a=0x000000FF, b=1, bi=0, ci=0 -> y=0x00000100, co=0, x=0x000000FE, out_valid 4 cycles after accept.
REQ-024 SHALL cover: a=5, b=7, bi=1, ci=1 -> y=0xFFFFFFFE, co=0, x=0xFFFFFFFD.
REQ-025 SHALL cover: a=0xFFFFFFFF, b=1, bi=0, ci=0 -> y=0x00000000, co=1 (carry through all 4 slices).
REQ-026 SHALL cover: out_ready low 3 cycles in DONE with in_valid high and new operands -> y/x/co unchanged, in_ready=0, no new op accepted until after the out handshake.
REQ-027 SHALL cover: rst pulsed during RUN at idx=2 -> next cycle IDLE, in_ready=1, out_valid=0, y=0; a subsequent op 3+4 yields y=7.
REQ-028 SHALL cover, with AP3_ALU_SEQ_FLAGS_EN: a=0x7FFFFFFF, b=1 -> ovf=1, zero=0; a=1, b=1, bi=1, ci=1 -> zero=1, co=1; without the macro, ovf and zero are absent.
